// File: rtl/logic_pod_decompression_pkg.sv
// logic_pod_decompression_pkg: compressed pod word encoding shared by compressor and decoder
package logic_pod_decompression_pkg;
    localparam logic LA_FMT_LITERAL = 1'b0;
    localparam logic LA_FMT_RUN = 1'b1;
    localparam int LA_RUN_LEN_BITS = 15;
    typedef struct packed {
        logic        format;
        logic [15:0] data;
    } la_comp_word_t;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} pod_state_e;
endpackage

// File: rtl/logic_pod_decompression.sv
// logic_pod_decompression: expands literal/run compressed words into 16-sample blocks with a block index
module logic_pod_decompression
    import logic_pod_decompression_pkg::*;
#(
    parameter int RUN_LEN_BITS = LA_RUN_LEN_BITS,
    parameter int IDX_WIDTH = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_format,
    input  logic [15:0]          in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [15:0]          out_data,
    output logic                 out_is_run,
    output logic [IDX_WIDTH-1:0] out_block_idx
);
    pod_state_e state_q, state_d;
    logic run_level_q, run_level_d;
    logic [RUN_LEN_BITS-1:0] run_rem_q, run_rem_d;
    logic out_valid_q, out_valid_d;
    logic [15:0] out_data_q, out_data_d;
    logic out_is_run_q, out_is_run_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic advance;
    la_comp_word_t word;

    assign word = '{format: in_format, data: in_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            run_level_q <= 1'b0;
            run_rem_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_is_run_q <= 1'b0;
            idx_q <= '0;
        end else begin
            state_q <= state_d;
            run_level_q <= run_level_d;
            run_rem_q <= run_rem_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            out_is_run_q <= out_is_run_d;
            idx_q <= idx_d;
        end
    end

    // The first block of a run word is emitted on acceptance, so RUN only covers the remainder.
    always_comb begin
        state_d = state_q;
        run_level_d = run_level_q;
        run_rem_d = run_rem_q;
        out_valid_d = out_valid_q;
        out_data_d = out_data_q;
        out_is_run_d = out_is_run_q;
        if (advance) begin
            if (state_q == RUN) begin
                out_valid_d = 1'b1;
                out_data_d = {16{run_level_q}};
                out_is_run_d = 1'b1;
                state_d = (run_rem_q == '0) ? IDLE : RUN;
                run_rem_d = (run_rem_q == '0) ? '0 : run_rem_q - RUN_LEN_BITS'(1);
            end else if (in_valid) begin
                out_valid_d = 1'b1;
                out_is_run_d = word.format == LA_FMT_RUN;
                out_data_d = out_is_run_d ? {16{word.data[15]}} : word.data;
                if (out_is_run_d && word.data[RUN_LEN_BITS-1:0] != '0) begin
                    state_d = RUN;
                    run_level_d = word.data[15];
                    run_rem_d = word.data[RUN_LEN_BITS-1:0] - RUN_LEN_BITS'(1);
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
        idx_d = (out_valid_q && out_ready) ? idx_q + IDX_WIDTH'(1) : idx_q;
    end

    always_comb begin
        advance = !out_valid_q || out_ready;
        in_ready = advance && state_q == IDLE && !rst;
        out_valid = out_valid_q;
        out_data = out_data_q;
        out_is_run = out_is_run_q;
        out_block_idx = idx_q;
    end
endmodule
